// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter_pkg
// Shared constants and FSM state encoding for the UART TX arbiter.
// Rev 1.0
// ============================================================================
package uart_tx_arbiter_pkg;

    localparam int C_DATA_W = 8;
    localparam int C_CNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter_if
// Producer handshake plus transmitter sequencing signals of the arbiter.
// Rev 1.0
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import uart_tx_arbiter_pkg::*;

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]          req_valid;
    logic [C_DATA_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]          req_ready;
    logic                        baud_tick;
    logic                        tx_busy;
    logic                        tx_start;
    logic [C_DATA_W-1:0]         tx_data;
    logic [ID_W-1:0]             grant_id;
    logic                        active;
    logic                        frame_done;
    logic                        err_timeout;

    modport master (
        output req_valid, req_data, baud_tick, tx_busy,
        input  req_ready, tx_start, tx_data, grant_id, active, frame_done, err_timeout
    );

    modport slave (
        input  req_valid, req_data, baud_tick, tx_busy,
        output req_ready, tx_start, tx_data, grant_id, active, frame_done, err_timeout
    );

endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter
// Combinational round-robin search for the first valid requester after pointer.
// Rev 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    pointer,
    output logic               any_valid,
    output logic [ID_W-1:0]    winner,
    output logic [NUM_REQ-1:0] onehot
);

    logic [ID_W-1:0] w_cand;

    // Walk from the farthest candidate back to pointer+1 so the nearest valid wins.
    always_comb begin
        winner = '0;
        w_cand = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = ID_W'((int'(pointer) + k) % NUM_REQ);
            if (valid[w_cand]) begin
                winner = w_cand;
            end
        end
    end

    assign any_valid = |valid;
    assign onehot    = any_valid ? (NUM_REQ'(1) << winner) : '0;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter
// Round-robin sharing of one UART transmitter: accept, start, track busy, gap.
// Rev 1.0
// ============================================================================
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int GAP_TICKS    = 0,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);

    localparam int                  ID_W       = $clog2(NUM_REQ);
    localparam logic [C_CNT_W-1:0]  C_TMO_LAST = C_CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [C_CNT_W-1:0]  C_GAP_LAST = C_CNT_W'(GAP_TICKS - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_grant_id;
    logic [ID_W-1:0]     w_winner;
    logic [NUM_REQ-1:0]  w_onehot;
    logic                w_any_valid;
    logic [C_CNT_W-1:0]  r_cnt;
    logic [C_CNT_W-1:0]  w_cnt_next;
    logic [C_DATA_W-1:0] r_tx_data;
    logic [C_DATA_W-1:0] w_bytes [NUM_REQ];
    logic                r_tx_start;
    logic                r_active;
    logic                r_frame_done;
    logic                r_err_timeout;
    logic                w_accept;
    logic                w_timeout;
    logic                w_done;
    logic                w_gap_end;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_bytes[gi] = bus.req_data[C_DATA_W*gi +: C_DATA_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .valid     (bus.req_valid),
        .pointer   (r_ptr),
        .any_valid (w_any_valid),
        .winner    (w_winner),
        .onehot    (w_onehot)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_timeout    = 1'b0;
        w_done       = 1'b0;
        w_gap_end    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_valid && !bus.tx_busy) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                w_cnt_next   = '0;
                w_state_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    w_state_next = ST_WAIT_DONE;
                end else if (r_cnt >= C_TMO_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    w_done       = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = (GAP_TICKS > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (bus.baud_tick) begin
                    if (r_cnt >= C_GAP_LAST) begin
                        w_gap_end    = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Pointer starts at the last index so the first grant after reset goes to requester 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt         <= '0;
            r_ptr         <= ID_W'(NUM_REQ - 1);
            r_grant_id    <= '0;
            r_tx_data     <= '0;
            r_tx_start    <= 1'b0;
            r_active      <= 1'b0;
            r_frame_done  <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_next;
            r_tx_start    <= w_accept;
            r_frame_done  <= w_done;
            r_err_timeout <= w_timeout;
            if (w_accept) begin
                r_tx_data  <= w_bytes[w_winner];
                r_grant_id <= w_winner;
                r_ptr      <= w_winner;
                r_active   <= 1'b1;
            end else if (w_timeout || w_gap_end || (w_done && (GAP_TICKS == 0))) begin
                r_active <= 1'b0;
            end
        end
    end

    assign bus.req_ready   = (w_accept && !reset) ? w_onehot : '0;
    assign bus.tx_start    = r_tx_start;
    assign bus.tx_data     = r_tx_data;
    assign bus.grant_id    = r_grant_id;
    assign bus.active      = r_active;
    assign bus.frame_done  = r_frame_done;
    assign bus.err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_arbiter
// Directed checks of the UART TX arbiter with a no-gap and a 3-tick-gap instance.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(4)) ifm ();
    uart_tx_arbiter_if #(.NUM_REQ(4)) ifg ();

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .GAP_TICKS    (0),
        .BUSY_TIMEOUT (4)
    ) dut_m (
        .clk   (clk),
        .reset (reset),
        .bus   (ifm)
    );

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .GAP_TICKS    (3),
        .BUSY_TIMEOUT (4)
    ) dut_g (
        .clk   (clk),
        .reset (reset),
        .bus   (ifg)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the expected grant, then step through the accept edge.
    task automatic accept_m(input int who, input logic [7:0] data, input string tag);
        int n = 0;
        #1;
        while (ifm.req_ready == '0 && n < 40) begin
            tick();
            n++;
        end
        chk_eq({tag, "_ready"}, 32'(ifm.req_ready), 32'(1) << who);
        tick();
        chk_eq({tag, "_start"},  32'(ifm.tx_start), 32'h1);
        chk_eq({tag, "_data"},   32'(ifm.tx_data),  32'(data));
        chk_eq({tag, "_gid"},    32'(ifm.grant_id), 32'(who));
        chk_eq({tag, "_active"}, 32'(ifm.active),   32'h1);
    endtask

    // Transmitter stand-in: busy rises right after tx_start, holds, then falls.
    task automatic frame_m(input int cyc, input string tag);
        tick();
        chk_eq({tag, "_start_low"}, 32'(ifm.tx_start), 32'h0);
        ifm.tx_busy = 1'b1;
        repeat (cyc) tick();
        chk_eq({tag, "_no_done"}, 32'(ifm.frame_done), 32'h0);
        ifm.tx_busy = 1'b0;
        tick();
        chk_eq({tag, "_done"},     32'(ifm.frame_done), 32'h1);
        chk_eq({tag, "_inactive"}, 32'(ifm.active),     32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        ifm.req_valid = 4'b0100;
        ifm.req_data  = 32'h00A5_0000;
        ifm.baud_tick = 1'b0;
        ifm.tx_busy   = 1'b0;
        ifg.req_valid = '0;
        ifg.req_data  = '0;
        ifg.baud_tick = 1'b0;
        ifg.tx_busy   = 1'b0;
        repeat (3) tick();

        chk_eq("rst_ready",  32'(ifm.req_ready),   32'h0);
        chk_eq("rst_start",  32'(ifm.tx_start),    32'h0);
        chk_eq("rst_data",   32'(ifm.tx_data),     32'h0);
        chk_eq("rst_gid",    32'(ifm.grant_id),    32'h0);
        chk_eq("rst_active", 32'(ifm.active),      32'h0);
        chk_eq("rst_done",   32'(ifm.frame_done),  32'h0);
        chk_eq("rst_tmo",    32'(ifm.err_timeout), 32'h0);

        // Contention: everyone valid, grants rotate 0,1,2,3,0.
        ifm.req_valid = 4'b1111;
        ifm.req_data  = 32'h1312_1110;
        reset         = 1'b0;
        for (int k = 0; k < 5; k++) begin
            accept_m(k % 4, 8'(16 + (k % 4)), "rr");
            frame_m(2, "rr");
        end
        ifm.req_valid = '0;

        // Single requester 2.
        ifm.req_valid = 4'b0100;
        ifm.req_data  = 32'h00A5_0000;
        accept_m(2, 8'hA5, "single");
        ifm.req_valid = '0;
        #1;
        chk_eq("single_ready_once", 32'(ifm.req_ready), 32'h0);
        frame_m(3, "single");

        // Transmitter busy at IDLE blocks acceptance.
        ifm.tx_busy   = 1'b1;
        ifm.req_valid = 4'b0010;
        ifm.req_data  = 32'h0000_5C00;
        repeat (3) begin
            #1;
            chk_eq("busyidle_hold", 32'(ifm.req_ready), 32'h0);
            tick();
        end
        ifm.tx_busy = 1'b0;
        accept_m(1, 8'h5C, "busyidle");
        ifm.req_valid = '0;
        frame_m(2, "busyidle");

        // Timeout: requester 3 wins, busy never rises, requester 0 served next.
        ifm.req_valid = 4'b1001;
        ifm.req_data  = 32'h7700_003C;
        accept_m(3, 8'h77, "tmo");
        ifm.req_valid = 4'b0001;
        tick();
        chk_eq("tmo_start_low", 32'(ifm.tx_start), 32'h0);
        repeat (3) tick();
        chk_eq("tmo_early", 32'(ifm.err_timeout), 32'h0);
        tick();
        chk_eq("tmo_pulse",    32'(ifm.err_timeout), 32'h1);
        chk_eq("tmo_inactive", 32'(ifm.active),      32'h0);
        chk_eq("tmo_no_done",  32'(ifm.frame_done),  32'h0);
        #1;
        chk_eq("tmo_next_ready", 32'(ifm.req_ready), 32'h1);
        accept_m(0, 8'h3C, "tmo_next");
        chk_eq("tmo_pulse_end", 32'(ifm.err_timeout), 32'h0);
        ifm.req_valid = '0;
        frame_m(2, "tmo_next");

        // Reset during WAIT_DONE.
        ifm.req_valid = 4'b0010;
        ifm.req_data  = 32'h0000_4200;
        accept_m(1, 8'h42, "rstmid");
        ifm.req_valid = 4'b0111;
        ifm.req_data  = 32'h0066_5544;
        tick();
        ifm.tx_busy = 1'b1;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk_eq("rstmid_data",   32'(ifm.tx_data),   32'h0);
        chk_eq("rstmid_gid",    32'(ifm.grant_id),  32'h0);
        chk_eq("rstmid_active", 32'(ifm.active),    32'h0);
        chk_eq("rstmid_ready",  32'(ifm.req_ready), 32'h0);
        tick();
        tick();
        reset = 1'b0;
        repeat (3) begin
            #1;
            chk_eq("rstmid_busy_hold", 32'(ifm.req_ready), 32'h0);
            tick();
        end
        ifm.tx_busy = 1'b0;
        accept_m(0, 8'h44, "post_rst");
        ifm.req_valid = '0;
        frame_m(2, "post_rst");

        // Gap of 3 baud ticks on the second instance.
        ifg.req_valid = 4'b0011;
        ifg.req_data  = 32'h0000_C1C0;
        #1;
        chk_eq("gap_ready0", 32'(ifg.req_ready), 32'h1);
        tick();
        chk_eq("gap_start0", 32'(ifg.tx_start), 32'h1);
        chk_eq("gap_data0",  32'(ifg.tx_data),  32'hC0);
        ifg.req_valid = 4'b0010;
        tick();
        ifg.tx_busy = 1'b1;
        tick();
        tick();
        ifg.tx_busy = 1'b0;
        tick();
        chk_eq("gap_done",        32'(ifg.frame_done), 32'h1);
        chk_eq("gap_active_done", 32'(ifg.active),     32'h1);
        for (int t = 1; t <= 3; t++) begin
            tick();
            #1;
            chk_eq("gap_wait_active", 32'(ifg.active),    32'h1);
            chk_eq("gap_wait_ready",  32'(ifg.req_ready), 32'h0);
            ifg.baud_tick = 1'b1;
            tick();
            ifg.baud_tick = 1'b0;
            #1;
            if (t < 3) begin
                chk_eq("gap_mid_active", 32'(ifg.active),    32'h1);
                chk_eq("gap_mid_ready",  32'(ifg.req_ready), 32'h0);
            end else begin
                chk_eq("gap_end_active", 32'(ifg.active),    32'h0);
                chk_eq("gap_end_ready",  32'(ifg.req_ready), 32'h2);
            end
        end
        tick();
        chk_eq("gap_start1", 32'(ifg.tx_start), 32'h1);
        chk_eq("gap_gid1",   32'(ifg.grant_id), 32'h1);
        chk_eq("gap_data1",  32'(ifg.tx_data),  32'hC1);
        chk_eq("gap_active1", 32'(ifg.active),  32'h1);
        ifg.req_valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one UART transmitter between NUM_REQ byte producers. Each requester offers a byte with a valid/ready handshake. The block then sequences the transmitter: it issues a one-cycle start, tracks busy through the whole frame, and optionally inserts an idle gap of baud ticks between frames. It sits between the producer logic and the existing UART TX datapath and baud generator.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
GAP_TICKS, 0, baud ticks of enforced line idle after each frame (0 = no gap, max 255)
BUSY_TIMEOUT, 4, clk cycles allowed after start for tx_busy to rise

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  flattened bytes; requester i uses bits [8i+7:8i]
req_ready  out  NUM_REQ  one-hot accept strobe; transfer when valid&ready
baud_tick  in  1  one-cycle tick from baud generator (same tick as transmitter)
tx_busy  in  1  transmitter busy
tx_start  out  1  start strobe to transmitter
tx_data  out  8  byte to transmitter
grant_id  out  $clog2(NUM_REQ)  index of requester currently owning the line
active  out  1  high from accept until return to IDLE
frame_done  out  1  one-cycle pulse when tx_busy falls for the granted frame
err_timeout  out  1  one-cycle pulse when tx_busy fails to rise

Behaviour:
- Reset (async assert, sync release): state IDLE. tx_start=0, tx_data=0, req_ready=0, grant_id=0, active=0, frame_done=0, err_timeout=0. RR pointer = NUM_REQ-1, so the first grant goes to requester 0. req_ready is forced 0 while reset is high.
- Arbitration: the winner is the first i with req_valid[i]=1, searching from pointer+1 upward with wrap-around. The pointer updates to the winner on accept only.
- IDLE: if any req_valid and tx_busy=0:
  - req_ready[winner]=1 combinationally (Mealy); all other bits are 0.
  - Same edge: latch tx_data<=byte, grant_id<=winner, active<=1; go to START.
  - If tx_busy=1, nothing is accepted.
- START: tx_start=1 (registered, exactly one cycle, the cycle after accept); go to WAIT_BUSY with timeout counter cleared.
- WAIT_BUSY:
  - tx_busy=1 -> WAIT_DONE.
  - Otherwise, when the counter reaches BUSY_TIMEOUT: pulse err_timeout, active<=0, go to IDLE. The byte is dropped and not retried.
- WAIT_DONE: when tx_busy=0, pulse frame_done. Go to GAP if GAP_TICKS>0, else IDLE with active<=0.
- GAP: count baud_tick. On the tick that makes the count equal GAP_TICKS: active<=0, go to IDLE. The counter clears on entry.
- tx_data and grant_id hold stable from accept until the next accept.
- Requester rules:
  - Must hold valid and data stable until ready.
  - Dropping valid before ready is legal; that request is simply not served.
  - Valid rising while the block is not IDLE waits for the next IDLE.
- Minimum accept-to-accept spacing with GAP_TICKS=0: START + WAIT_BUSY + frame + 1 IDLE cycle.
- reset mid-frame: all outputs return to reset values immediately. A transmitter that is already busy finishes independently. After release, the first accept waits in IDLE until tx_busy=0.

Decomposition:
- Shared package: FSM state encoding (IDLE, START, WAIT_BUSY, WAIT_DONE, GAP), UART data width constant 8.
- One natural sub-module: rr_arbiter, a combinational round-robin winner/any-valid finder from (valid, pointer).
- Top level holds the FSM, counters and latches.

Test Plan:
- Single requester: req_valid[2]=1, data 0xA5, idle transmitter -> req_ready=4'b0100 for one cycle, tx_start one cycle later with tx_data=0xA5, grant_id=2, frame_done after tx_busy falls.
- Contention: all four valid continuously, data 0x10..0x13 -> grants in order 0,1,2,3,0, one byte each; no requester is granted twice before the others.
- Gap: GAP_TICKS=3, two back-to-back requests -> second req_ready is asserted only after the 3rd baud_tick following frame_done; active stays high through the gap.
- Timeout: tx_busy held 0 after tx_start -> err_timeout pulses BUSY_TIMEOUT cycles after WAIT_BUSY entry, no frame_done, return to IDLE, next requester served.
- Reset mid-frame: assert reset during WAIT_DONE -> outputs zero asynchronously. After release with tx_busy still 1, no req_ready until tx_busy=0; the next grant goes to requester 0.
- Busy transmitter at IDLE: tx_busy=1 externally, req_valid=1 -> req_ready stays 0 until tx_busy=0.
